// File: rtl/rsp_fifo_pkg.sv
// rsp_fifo_pkg
// Shared constants and helpers for the single-clock response FIFO.
//   RSP_DATA_W     : default response word width
//   RSP_FIFO_DEPTH : default entry count
//   ptr_w()        : pointer width (index bits plus one wrap bit)
package rsp_fifo_pkg;

  localparam int RSP_DATA_W     = 128;
  localparam int RSP_FIFO_DEPTH = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rsp_fifo_sync_if.sv
// rsp_fifo_sync_if
// Push/pop handshake bundle of the response FIFO plus its status outputs.
//   push_valid, push_ready, push_rsp_data : producer side
//   pop_valid, pop_ready, pop_rsp_data    : consumer side (first-word-fall-through)
//   count, almost_full                    : occupancy status
// Handshake: a word moves on a side only in a cycle where valid and ready
// are both 1 at the rising edge. The producer holds push_valid and
// push_rsp_data until push_ready; the FIFO holds pop_valid and pop_rsp_data
// stable until the word is popped or the FIFO is flushed.
// Modports: master = producer/consumer driving the FIFO, slave = the FIFO.
interface rsp_fifo_sync_if
  import rsp_fifo_pkg::*;
#(
  parameter int DATA_W = RSP_DATA_W,
  parameter int DEPTH  = RSP_FIFO_DEPTH
) ();

  localparam int CNT_W = ptr_w(DEPTH);

  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_rsp_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_rsp_data;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  modport master (
    output push_valid, push_rsp_data, pop_ready,
    input  push_ready, pop_valid, pop_rsp_data, count, almost_full
  );

  modport slave (
    input  push_valid, push_rsp_data, pop_ready,
    output push_ready, pop_valid, pop_rsp_data, count, almost_full
  );

endinterface

// File: rtl/rsp_fifo_ram.sv
// rsp_fifo_ram
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read
// port. The asynchronous read is what lets the FIFO present its head word
// combinationally, and it maps onto distributed (LUT) RAM.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module rsp_fifo_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  (* syn_ramstyle = "distributed_ram" *)
  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array: keeps it mappable onto LUT RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rsp_fifo_sync.sv
// rsp_fifo_sync
// Single-clock response FIFO, valid/ready on both sides, first-word-fall-
// through output, occupancy count, programmable almost-full and synchronous
// flush.
//   clk, rstn   : clock (rising edge), asynchronous active-low reset
//   flush       : clears all stored entries at the next edge
//   bus         : rsp_fifo_sync_if.slave (push/pop handshakes, count,
//                 almost_full)
// Optional (macro RSP_FIFO_WMARK_EN):
//   wmark_clr   : reload max_count with the current count
//   max_count   : highest occupancy since reset, flush or wmark_clr
module rsp_fifo_sync
  import rsp_fifo_pkg::*;
#(
  parameter int DATA_W       = RSP_DATA_W,
  parameter int DEPTH        = RSP_FIFO_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
`ifdef RSP_FIFO_WMARK_EN
  input  logic                      wmark_clr,
  output logic [ptr_w(DEPTH)-1:0]   max_count,
`endif
  rsp_fifo_sync_if.slave            bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] cnt;
  logic          init_done;
  logic          empty;
  logic          full;
  logic          push_fire;
  logic          pop_fire;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index bits with differing wrap bits mean full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  // push_ready depends only on registered state, so a pop in a full cycle
  // frees a slot that becomes visible one cycle later.
  assign bus.push_ready = !full && init_done;
  assign bus.pop_valid  = !empty;

  assign push_fire = bus.push_valid && bus.push_ready;
  assign pop_fire  = bus.pop_valid && bus.pop_ready;

  // Modulo subtraction through the wrap bit gives 0..DEPTH directly.
  assign cnt             = wptr - rptr;
  assign bus.count       = cnt;
  assign bus.almost_full = (cnt >= PW'(AFULL_THRESH));

  // Holds off pushes for the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_fire) wptr <= wptr + PW'(1);
      if (pop_fire)  rptr <= rptr + PW'(1);
    end
  end

  rsp_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_fire && !flush),
    .waddr (wptr[AW-1:0]),
    .wdata (bus.push_rsp_data),
    .raddr (rptr[AW-1:0]),
    .rdata (bus.pop_rsp_data)
  );

`ifdef RSP_FIFO_WMARK_EN
  logic [PW-1:0] max_q;

  // Tracks the registered count, so it trails a count increase by a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      max_q <= '0;
    end else if (flush) begin
      max_q <= '0;
    end else if (wmark_clr) begin
      max_q <= cnt;
    end else if (cnt > max_q) begin
      max_q <= cnt;
    end
  end

  assign max_count = max_q;
`endif

endmodule

// File: tb/tb_rsp_fifo_sync.sv
// tb_rsp_fifo_sync
// Directed bench for rsp_fifo_sync with DATA_W=128, DEPTH=8, AFULL_THRESH=6.
// Fill/drain is a table of {inputs, expected outputs after the edge}; the
// remaining corner cases are hand-written sequences.
module tb_rsp_fifo_sync;

  localparam int DW    = 128;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;
`ifdef RSP_FIFO_WMARK_EN
  logic          wmark_clr = 1'b0;
  logic [CW-1:0] max_count;
`endif

  always #5 clk = ~clk;

  rsp_fifo_sync_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  rsp_fifo_sync #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
`ifdef RSP_FIFO_WMARK_EN
    .wmark_clr (wmark_clr),
    .max_count (max_count),
`endif
    .bus       (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic pr, input logic [DW-1:0] d);
    bus.push_valid    = pv;
    bus.pop_ready     = pr;
    bus.push_rsp_data = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          push_valid;
    logic          pop_ready;
    logic [DW-1:0] data;
    logic          exp_push_ready;
    logic          exp_pop_valid;
    logic [CW-1:0] exp_count;
    logic          exp_afull;
    logic [DW-1:0] exp_head;
  } vec_t;

  vec_t vecs[16];

  task automatic set_vec(input int idx, input logic pv, input logic pr, input logic [DW-1:0] d,
                         input logic epr, input logic epv, input logic [CW-1:0] ecnt,
                         input logic eaf, input logic [DW-1:0] ehead);
    vecs[idx].push_valid     = pv;
    vecs[idx].pop_ready      = pr;
    vecs[idx].data           = d;
    vecs[idx].exp_push_ready = epr;
    vecs[idx].exp_pop_valid  = epv;
    vecs[idx].exp_count      = ecnt;
    vecs[idx].exp_afull      = eaf;
    vecs[idx].exp_head       = ehead;
  endtask

  initial begin
    //       idx pv pr data      p_rdy p_val cnt     afull head
    set_vec(0,  1, 0, DW'(1),  1,    1,    4'd1,  0,    DW'(1));
    set_vec(1,  1, 0, DW'(2),  1,    1,    4'd2,  0,    DW'(1));
    set_vec(2,  1, 0, DW'(3),  1,    1,    4'd3,  0,    DW'(1));
    set_vec(3,  1, 0, DW'(4),  1,    1,    4'd4,  0,    DW'(1));
    set_vec(4,  1, 0, DW'(5),  1,    1,    4'd5,  0,    DW'(1));
    set_vec(5,  1, 0, DW'(6),  1,    1,    4'd6,  1,    DW'(1));
    set_vec(6,  1, 0, DW'(7),  1,    1,    4'd7,  1,    DW'(1));
    set_vec(7,  1, 0, DW'(8),  0,    1,    4'd8,  1,    DW'(1));
    set_vec(8,  0, 1, DW'(0),  1,    1,    4'd7,  1,    DW'(2));
    set_vec(9,  0, 1, DW'(0),  1,    1,    4'd6,  1,    DW'(3));
    set_vec(10, 0, 1, DW'(0),  1,    1,    4'd5,  0,    DW'(4));
    set_vec(11, 0, 1, DW'(0),  1,    1,    4'd4,  0,    DW'(5));
    set_vec(12, 0, 1, DW'(0),  1,    1,    4'd3,  0,    DW'(6));
    set_vec(13, 0, 1, DW'(0),  1,    1,    4'd2,  0,    DW'(7));
    set_vec(14, 0, 1, DW'(0),  1,    1,    4'd1,  0,    DW'(8));
    set_vec(15, 0, 1, DW'(0),  1,    0,    4'd0,  0,    DW'(0));

    drive(1'b0, 1'b0, '0);

    // ---- reset state ----
    #2;
    check("rst_push_ready", DW'(bus.push_ready), DW'(0));
    check("rst_pop_valid", DW'(bus.pop_valid), DW'(0));
    check("rst_count", DW'(bus.count), DW'(0));
    check("rst_afull", DW'(bus.almost_full), DW'(0));
    step();
    step();
    #2;
    rstn = 1'b1;
    check("init_push_ready_pre_edge", DW'(bus.push_ready), DW'(0));
    step();
    check("init_push_ready_post_edge", DW'(bus.push_ready), DW'(1));
    check("init_pop_valid", DW'(bus.pop_valid), DW'(0));
    check("init_count", DW'(bus.count), DW'(0));

    // ---- fill to full, drain in order (table) ----
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].push_valid, vecs[i].pop_ready, vecs[i].data);
      step();
      check($sformatf("vec%0d_push_ready", i), DW'(bus.push_ready), DW'(vecs[i].exp_push_ready));
      check($sformatf("vec%0d_pop_valid", i), DW'(bus.pop_valid), DW'(vecs[i].exp_pop_valid));
      check($sformatf("vec%0d_count", i), DW'(bus.count), DW'(vecs[i].exp_count));
      check($sformatf("vec%0d_afull", i), DW'(bus.almost_full), DW'(vecs[i].exp_afull));
      if (vecs[i].exp_pop_valid)
        check($sformatf("vec%0d_head", i), bus.pop_rsp_data, vecs[i].exp_head);
    end
    drive(1'b0, 1'b0, '0);
`ifdef RSP_FIFO_WMARK_EN
    step();
    check("wmark_after_fill", DW'(max_count), DW'(8));
`endif

    // ---- full FIFO with simultaneous push and pop ----
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, DW'(32'h11 + i));
      step();
    end
    drive(1'b1, 1'b1, DW'(32'h19));
    check("full_push_ready", DW'(bus.push_ready), DW'(0));
    check("full_head", bus.pop_rsp_data, DW'(32'h11));
    step();
    check("full_pop_only_count", DW'(bus.count), DW'(7));
    check("full_pop_only_head", bus.pop_rsp_data, DW'(32'h12));
    drive(1'b1, 1'b0, DW'(32'h19));
    check("full_push_ready_next", DW'(bus.push_ready), DW'(1));
    step();
    drive(1'b0, 1'b0, '0);
    check("full_refill_count", DW'(bus.count), DW'(8));
    check("full_refill_push_ready", DW'(bus.push_ready), DW'(0));
    drive(1'b0, 1'b1, '0);
    for (int k = 0; k < DEPTH; k++) begin
      check($sformatf("full_drain%0d", k), bus.pop_rsp_data, DW'(32'h12 + k));
      step();
    end
    drive(1'b0, 1'b0, '0);
    check("full_drain_pop_valid", DW'(bus.pop_valid), DW'(0));
`ifdef RSP_FIFO_WMARK_EN
    wmark_clr = 1'b1;
    step();
    wmark_clr = 1'b0;
    check("wmark_clr", DW'(max_count), DW'(0));
`endif

    // ---- continuous stream, 40 words through 8 entries ----
    drive(1'b1, 1'b1, DW'(32'h100));
    exp_q.push_back(DW'(32'h100));
    step();
    for (int i = 1; i < 40; i++) begin
      drive(1'b1, 1'b1, DW'(32'h100 + i));
      check($sformatf("stream%0d_pop_valid", i), DW'(bus.pop_valid), DW'(1));
      check($sformatf("stream%0d_push_ready", i), DW'(bus.push_ready), DW'(1));
      check($sformatf("stream%0d_data", i), bus.pop_rsp_data, exp_q.pop_front());
      exp_q.push_back(DW'(32'h100 + i));
      step();
      check($sformatf("stream%0d_count", i), DW'(bus.count), DW'(1));
    end
    drive(1'b0, 1'b1, '0);
    check("stream_last_data", bus.pop_rsp_data, exp_q.pop_front());
    step();
    drive(1'b0, 1'b0, '0);
    check("stream_end_count", DW'(bus.count), DW'(0));
    check("stream_end_pop_valid", DW'(bus.pop_valid), DW'(0));
    check("stream_q_empty", DW'(exp_q.size()), DW'(0));

    // ---- flush with a concurrent push ----
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, DW'(32'h21 + i));
      step();
    end
    check("pre_flush_count", DW'(bus.count), DW'(4));
    drive(1'b1, 1'b0, DW'(32'hdead));
    flush = 1'b1;
    check("flush_push_ready", DW'(bus.push_ready), DW'(1));
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    check("flush_count", DW'(bus.count), DW'(0));
    check("flush_pop_valid", DW'(bus.pop_valid), DW'(0));
    step();
    check("flush_discard_count", DW'(bus.count), DW'(0));
`ifdef RSP_FIFO_WMARK_EN
    check("flush_wmark", DW'(max_count), DW'(0));
`endif

    // ---- asynchronous reset with entries stored ----
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, DW'(32'h31 + i));
      step();
    end
    drive(1'b0, 1'b0, '0);
    check("pre_reset_count", DW'(bus.count), DW'(5));
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_count", DW'(bus.count), DW'(0));
    check("async_rst_pop_valid", DW'(bus.pop_valid), DW'(0));
    check("async_rst_push_ready", DW'(bus.push_ready), DW'(0));
    check("async_rst_afull", DW'(bus.almost_full), DW'(0));
`ifdef RSP_FIFO_WMARK_EN
    check("async_rst_wmark", DW'(max_count), DW'(0));
`endif
    step();
    #2;
    rstn = 1'b1;
    step();
    check("post_rst_push_ready", DW'(bus.push_ready), DW'(1));
    check("post_rst_count", DW'(bus.count), DW'(0));

    // ---- final report ----
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsp_fifo_sync.md
# rsp_fifo_sync

Parametrised single-clock response FIFO with valid/ready on both sides, occupancy count, programmable almost-full, and synchronous flush. Sits between the memory/peripheral response path and the core-side consumer wherever both ends share one clock. It replaces vendor FIFO macros with portable RTL, so the same response buffering works on any FPGA target.

## Interface
- DATA_W, 128: response word width in bits.
- DEPTH, 16: entry count; power of two, minimum 2.
- AFULL_THRESH, DEPTH-2: `almost_full` asserts when `count >= AFULL_THRESH`; legal range 1..DEPTH.
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all stored entries.
- push_valid  in  1  producer offers `push_rsp_data`.
- push_ready  out  1  FIFO accepts a word this cycle.
- push_rsp_data  in  DATA_W  write data.
- pop_valid  out  1  head word present on `pop_rsp_data`.
- pop_ready  in  1  consumer takes the head word.
- pop_rsp_data  out  DATA_W  head word (first-word-fall-through).
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  out  1  occupancy at or above AFULL_THRESH.

## Operation
- Storage: DEPTH x DATA_W array. Write pointer `wptr` and read pointer `rptr`, each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
- empty = (wptr == rptr); full = index bits equal and wrap bits differ; count = wptr - rptr, modulo 2^(ptr width).
- push fire = push_valid & push_ready. It writes `mem[wptr]` and increments wptr.
- pop fire = pop_valid & pop_ready. It increments rptr.
- push_ready = !full & init_done. `init_done` is a register cleared by reset and set on the first clk edge after rstn deasserts.
- pop_valid = !empty. `pop_rsp_data` = mem[rptr index], read combinationally. The value is X-don't-care while pop_valid is 0.
- Simultaneous push and pop fire: both pointers advance and count is unchanged.
- Full: push_ready is 0. A pop in the same cycle does not enable a push that cycle; push_ready rises the next cycle.
- Empty: pop_valid is 0. A push in the same cycle is not bypassed; it appears the next cycle.
- flush = 1: both pointers are set to 0 at the next edge. flush has priority over push and pop fire. Any push attempted in the flush cycle is discarded, and push_ready stays asserted if not full.
- Handshake rules:
  - The producer holds push_valid/data until push_ready.
  - The FIFO holds pop_valid and data stable until pop fire or flush.
- Pointers wrap naturally through the extra bit. There is no special case at DEPTH-1 to 0.

## Timing
- Reset values (while rstn low):
  - wptr = rptr = 0.
  - push_ready = 0, pop_valid = 0, count = 0, almost_full = 0.
  - Watermark (if enabled) = 0.
- Reset mid-operation: contents are lost immediately and asynchronously. Outputs take their reset values without waiting for a clock edge.
- Push-to-pop latency: 1 cycle. A word pushed at edge N is visible with pop_valid = 1 after edge N.
- count and almost_full are registered-pointer derived. They update the cycle after a fire.
- Sustained throughput: 1 word/cycle with both sides active, at any occupancy 1..DEPTH-1.

## Configuration
- RSP_FIFO_WMARK_EN defined:
  - Adds output `max_count` (width as count), the highest occupancy since reset or the last flush. It updates the cycle after count increases.
  - Adds input `wmark_clr`, which resets `max_count` to the current count.
- RSP_FIFO_WMARK_EN undefined: neither port exists and no watermark logic is generated.

## Structure
- Package `rsp_fifo_pkg`:
  - RSP_DATA_W = 128.
  - RSP_FIFO_DEPTH = 16.
  - Pointer-width function ptr_w(depth) = $clog2(depth)+1.
- Sub-module `rsp_fifo_ram`: DEPTH x DATA_W, one synchronous write port, one asynchronous read port. It must infer distributed RAM on Gowin. Pointer, flag and flush logic stays in `rsp_fifo_sync`.

## Test plan
All scenarios use DATA_W=128, DEPTH=8, AFULL_THRESH=6.
- Reset release → push_ready = 0 for the first edge, then 1; pop_valid = 0; count = 0.
- Push 8 words 0x1..0x8 with pop_ready = 0 → almost_full rises after the 6th push; push_ready = 0 after the 8th; count = 8. Pop all 8 → data 0x1..0x8 in order, then pop_valid = 0.
- Full FIFO, push_valid = 1 and pop_ready = 1 in the same cycle → only the pop fires; count = 7; push is accepted next cycle; count = 8.
- Continuous push and pop for 40 words, 0x100 onwards → 1 word/cycle, pointers wrap 5 times, output order intact, count stays 1.
- Four entries stored, then flush = 1 together with push_valid = 1 → next cycle count = 0, pop_valid = 0; the pushed word is discarded.
- rstn pulled low with 5 entries stored → count = 0, pop_valid = 0 without a clock edge. With RSP_FIFO_WMARK_EN defined, max_count reads 8 after the second scenario and 0 after this reset.
